// File: rtl/culsans_tohost_pkg.sv
// culsans_tohost_pkg: address map, exit encodings and FSM state type for tohost_exit_unit.
package culsans_tohost_pkg;
    localparam int          SlotShift     = 3;
    localparam logic [7:0]  ConsoleOffset = 8'h80;
    localparam logic [31:0] ExitPass      = 32'h0000_0001;
    localparam logic [31:0] ExitTimeout   = 32'hFFFF_FFFF;
    localparam int          FifoDepth     = 4;

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_e;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/tohost_char_fifo.sv
// tohost_char_fifo: 4-entry byte FIFO feeding the console stream (used only with TOHOST_CONSOLE_EN).
module tohost_char_fifo
    import culsans_tohost_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);
    logic [7:0] mem [FifoDepth];
    logic [1:0] wp, rp;
    logic [2:0] cnt;
    logic push_ok, pop_ok;

    assign full_o  = cnt == 3'(FifoDepth);
    assign empty_o = cnt == 3'd0;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = empty_o ? 8'h00 : mem[rp];

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wp] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + 2'd1;
            if (pop_ok) rp <= rp + 2'd1;
            cnt <= cnt + 3'(push_ok) - 3'(pop_ok);
        end
    end
endmodule

// File: rtl/tohost_exit_unit.sv
// tohost_exit_unit: per-core tohost slots deciding PASS/FAIL/TIMEOUT exit status.
// Define TOHOST_CONSOLE_EN to enable the console byte FIFO at offset 0x80.
module tohost_exit_unit
    import culsans_tohost_pkg::*;
#(
    parameter int          NumCores      = 2,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  be_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic [31:0] exit_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic [7:0]  char_data_o
);
    localparam logic [4:0]  NumSlots = 5'(NumCores);
    localparam logic [31:0] TmoLast  = TimeoutCycles == 0 ? 32'd0 : 32'(TimeoutCycles - 1);

    state_e state_q, state_d;
    logic [31:0] slots [8];
    logic [31:0] cur, merged, exit_d, cnt_q;
    logic [NumCores-1:0] done_q, done_d, sel;
    logic [2:0] idx;
    logic slot_hit, con_hit, fifo_full, slot_wr, evt, tmo;

    assign idx      = addr_i[SlotShift +: 3];
    assign slot_hit = addr_i[7:SlotShift] < NumSlots;
    assign con_hit  = addr_i[7:SlotShift] == ConsoleOffset[7:SlotShift];
    assign gnt_o    = req_i & ~(we_i & con_hit & fifo_full);
    assign cur      = slots[idx];
    assign merged   = (cur & ~be_mask(be_i[3:0])) | (wdata_i[31:0] & be_mask(be_i[3:0]));
    assign slot_wr  = gnt_o & we_i & slot_hit;
    assign evt      = slot_wr & be_i[0] & merged[0];
    assign tmo      = (TimeoutCycles != 0) && (cnt_q == TmoLast);

    always_comb begin
        state_d = state_q;
        exit_d  = exit_o;
        done_d  = done_q;
        for (int i = 0; i < NumCores; i++) sel[i] = idx == 3'(i);
        // an event in the timeout cycle takes priority over the watchdog
        if (state_q == ST_RUN) begin
            if (evt && merged[31:1] != '0) begin
                state_d = ST_FAIL;
                exit_d  = merged;
            end else if (evt) begin
                done_d = done_q | sel;
                state_d = &done_d ? ST_PASS : ST_RUN;
                exit_d  = &done_d ? ExitPass : exit_o;
            end else if (tmo) begin
                state_d = ST_TIMEOUT;
                exit_d  = ExitTimeout;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_RUN;
            done_q   <= '0;
            exit_o   <= '0;
            cnt_q    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            for (int i = 0; i < 8; i++) slots[i] <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            exit_o   <= exit_d;
            rvalid_o <= gnt_o;
            rdata_o  <= (gnt_o & ~we_i & slot_hit) ? {32'b0, cur} : 64'b0;
            if (state_q == ST_RUN && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
            if (slot_wr) slots[idx] <= merged;
        end
    end

`ifdef TOHOST_CONSOLE_EN
    logic fifo_empty;
    logic unused_bits;
    assign unused_bits = ^{be_i[7:4], wdata_i[63:32], addr_i[2:0]};
    assign char_valid_o = ~fifo_empty;

    tohost_char_fifo u_char_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (gnt_o & we_i & con_hit & be_i[0]),
        .data_i (wdata_i[7:0]),
        .pop_i  (char_valid_o & char_ready_i),
        .data_o (char_data_o),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );
`else
    logic unused_bits;
    assign unused_bits  = ^{be_i[7:4], wdata_i[63:32], addr_i[2:0], char_ready_i};
    assign fifo_full    = 1'b0;
    assign char_valid_o = 1'b0;
    assign char_data_o  = 8'h00;
`endif
endmodule

// File: tb/tb_tohost_exit_unit.sv
// tb_tohost_exit_unit: directed checks of tohost_exit_unit with NumCores=2, TimeoutCycles=100.
module tb_tohost_exit_unit;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, char_ready = 1'b0;
    logic [7:0]  addr = '0, be = '0;
    logic [63:0] wdata = '0;
    logic        gnt, rvalid, char_valid, g;
    logic [63:0] rdata;
    logic [31:0] exit_code;
    logic [7:0]  char_data;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    tohost_exit_unit #(.NumCores(2), .TimeoutCycles(100)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .exit_o(exit_code), .char_valid_o(char_valid),
        .char_ready_i(char_ready), .char_data_o(char_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one bus cycle; returns #1 after the grant edge with gnt sampled before it
    task automatic bus(input logic w, input logic [7:0] a, input logic [63:0] d,
                       input logic [7:0] b, output logic gg);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        #1 gg = gnt;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req = 1'b0; we = 1'b0; char_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_exit", exit_code, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_char_valid", char_valid, 0);
        @(negedge clk) rst = 1'b0;

        bus(1, 8'h00, 64'h1, 8'h0F, g);
        check("pass_gnt0", g, 1);
        check("pass_rvalid0", rvalid, 1);
        check("pass_rdata_wr", rdata, 0);
        check("pass_exit_first", exit_code, 0);
        bus(1, 8'h08, 64'h1, 8'h0F, g);
        check("pass_exit_second", exit_code, 32'h1);
        bus(1, 8'h00, 64'h9, 8'h0F, g);
        check("pass_sticky", exit_code, 32'h1);
        bus(0, 8'h00, 64'h0, 8'h00, g);
        check("pass_slot_updated", rdata, 64'h9);

        do_reset();
        bus(1, 8'h08, 64'h7, 8'h0F, g);
        check("fail_exit", exit_code, 32'h7);
        bus(1, 8'h00, 64'h1, 8'h0F, g);
        check("fail_sticky", exit_code, 32'h7);
        @(negedge clk) rst = 1'b1;
        #1;
        check("fail_rst_exit", exit_code, 0);
        check("fail_rst_rvalid", rvalid, 0);
        @(negedge clk) rst = 1'b0;
        bus(1, 8'h08, 64'h1, 8'h0F, g);
        check("rerun_half", exit_code, 0);
        bus(1, 8'h00, 64'h1, 8'h0F, g);
        check("rerun_pass", exit_code, 32'h1);

        do_reset();
        bus(1, 8'h00, 64'h1, 8'h0F, g);
        bus(1, 8'h00, 64'h1, 8'h0F, g);
        check("dup_exit", exit_code, 0);
        bus(0, 8'h00, 64'h0, 8'h00, g);
        check("rd_rvalid", rvalid, 1);
        check("rd_data", rdata, 64'h1);
        @(posedge clk) #1;
        check("rd_rvalid_drop", rvalid, 0);
        check("rd_rdata_idle", rdata, 0);

        bus(1, 8'h40, 64'h1, 8'h0F, g);
        check("unmapped_gnt", g, 1);
        check("unmapped_exit", exit_code, 0);
        bus(0, 8'h40, 64'h0, 8'h00, g);
        check("unmapped_rd", rdata, 0);
        bus(1, 8'h08, 64'h300, 8'h02, g);
        check("be1_no_event", exit_code, 0);
        bus(1, 8'h08, 64'hFFFF_FFFF_0000_0002, 8'hF1, g);
        check("bit0_clear_no_event", exit_code, 0);
        bus(0, 8'h08, 64'h0, 8'h00, g);
        check("merge_rd", rdata, 64'h302);
        bus(1, 8'h08, 64'h1, 8'h01, g);
        check("merge_fail", exit_code, 32'h301);

        do_reset();
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h00;
        #2 rst = 1'b1;
        @(posedge clk) #1;
        check("midrd_rvalid", rvalid, 0);
        req = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        check("midrd_after", rvalid, 0);
        bus(0, 8'h00, 64'h0, 8'h00, g);
        check("rsp_rvalid", rvalid, 1);
        rst = 1'b1;
        #1;
        check("rsp_rst_rvalid", rvalid, 0);
        @(negedge clk) rst = 1'b0;

`ifdef TOHOST_CONSOLE_EN
        bus(1, 8'h80, 64'h41, 8'h01, g);
        check("con_gnt_a", g, 1);
        check("con_valid_a", char_valid, 1);
        check("con_data_a", char_data, 8'h41);
        for (int i = 1; i < 4; i++) begin
            bus(1, 8'h80, 64'(8'h41 + i), 8'h01, g);
            check("con_gnt_fill", g, 1);
        end
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h80; wdata = 64'h45; be = 8'h01;
        #1 check("con_full_gnt", gnt, 0);
        char_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("con_valid", char_valid, 1);
            check("con_data", char_data, 64'(8'h41 + k));
            if (k == 1) check("con_e_gnt", gnt, 1);
            @(posedge clk) #1;
            if (k == 1) begin req = 1'b0; we = 1'b0; end
        end
        check("con_drained", char_valid, 0);
        char_ready = 1'b0;
`else
        bus(1, 8'h80, 64'h41, 8'h01, g);
        check("con_off_gnt", g, 1);
        check("con_off_valid", char_valid, 0);
        check("con_off_data", char_data, 0);
        check("con_off_exit", exit_code, 0);
        bus(0, 8'h80, 64'h0, 8'h00, g);
        check("con_off_rvalid", rvalid, 1);
        check("con_off_rd", rdata, 0);
`endif

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        repeat (99) @(posedge clk);
        #1 check("tmo_before", exit_code, 0);
        @(posedge clk) #1;
        check("tmo_exit", exit_code, 32'hFFFF_FFFF);
        bus(1, 8'h00, 64'h1, 8'h0F, g);
        bus(1, 8'h08, 64'h1, 8'h0F, g);
        check("tmo_sticky", exit_code, 32'hFFFF_FFFF);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        req = 1'b1; we = 1'b1; addr = 8'h00; wdata = 64'h1; be = 8'h0F;
        @(posedge clk) #1 req = 1'b0;
        repeat (98) @(posedge clk);
        #1 check("race_before", exit_code, 0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 8'h08; wdata = 64'h1; be = 8'h0F;
        @(posedge clk) #1 req = 1'b0;
        check("race_event_wins", exit_code, 32'h1);
        @(posedge clk) #1;
        check("race_stays_pass", exit_code, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tohost_exit_unit.md
TOHOST_EXIT_UNIT -- requirements
Module: tohost_exit_unit

Interface
REQ-001 Parameter NumCores, default 2, number of tohost slots (1..8) SHALL be supported.
REQ-002 Parameter TimeoutCycles, default 0, watchdog limit in cycles; 0 SHALL disable the watchdog.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 req_i  input  1  request valid.
REQ-006 we_i  input  1  1 = write, 0 = read.
REQ-007 addr_i  input  8  byte offset inside the unit; bits [2:0] ignored.
REQ-008 wdata_i  input  64  write data.
REQ-009 be_i  input  8  byte enables.
REQ-010 gnt_o  output  1  request accepted this cycle.
REQ-011 rvalid_o  output  1  response valid, one cycle after grant, for reads and writes.
REQ-012 rdata_o  output  64  read data, valid with rvalid_o, else 0.
REQ-013 exit_o  output  32  bit0 = finished, [31:1] = exit code.
REQ-014 char_valid_o / char_ready_i / char_data_o  output / input / output  1 / 1 / 8  console byte stream, valid/ready.

Function
REQ-015 Slot i SHALL sit at offset 8*i; console at 0x80; all other offsets SHALL be unmapped.
REQ-016 gnt_o SHALL equal req_i, except a console write while the console FIFO is full SHALL see gnt_o = 0.
REQ-017 A granted write to slot i SHALL merge wdata_i[31:0] into the slot under be_i[3:0]; be_i[7:4] ignored.
REQ-018 A slot write SHALL be a tohost event only when be_i[0] = 1 and merged bit0 = 1.
REQ-019 Reads SHALL return {32'b0, slot} for slots and 0 for unmapped or console offsets; unmapped writes SHALL be dropped.
REQ-020 FSM states RUN, PASS, FAIL, TIMEOUT; only RUN SHALL accept events; other states SHALL be sticky until reset.
REQ-021 RUN->FAIL on an event with merged[31:1] != 0; exit_o SHALL become merged value the cycle after grant.
REQ-022 RUN->PASS when every slot has seen a code-0 event; exit_o SHALL become 32'h1 the cycle after the last event.
REQ-023 Repeated code-0 events from one core SHALL count once; in PASS/FAIL/TIMEOUT slot writes SHALL still update slots but SHALL NOT change exit_o.
REQ-024 Watchdog: 32-bit cycle counter counts in RUN; at TimeoutCycles it SHALL go RUN->TIMEOUT, exit_o = 32'hFFFF_FFFF; counter SHALL saturate.
REQ-025 An event in the same cycle as timeout SHALL win over the timeout.
REQ-026 exit_o SHALL be 0 throughout RUN.

Reset
REQ-027 On rst_i: FSM=RUN, slots=0, done mask=0, counter=0, FIFO empty, exit_o=0, rvalid_o=0, rdata_o=0, char_valid_o=0.
REQ-028 Reset asserted mid-transaction SHALL drop the pending response; no rvalid_o after reset.

Configuration
REQ-029 Macro TOHOST_CONSOLE_EN defined: granted write to 0x80 with be_i[0] = 1 SHALL push wdata_i[7:0] into a 4-entry FIFO drained over char_*, first byte visible the cycle after grant.
REQ-030 Macro undefined: char_* ports SHALL remain, char_valid_o = 0 and char_data_o = 0 tied; writes to 0x80 SHALL be granted and dropped.

Structure
REQ-031 Package culsans_tohost_pkg SHALL hold slot/console offsets, exit encodings (PASS 32'h1, TIMEOUT 32'hFFFF_FFFF) and the FSM state enum.
REQ-032 Console FIFO SHALL be sub-module tohost_char_fifo (depth 4, 8-bit, full/empty flags), instantiated only under TOHOST_CONSOLE_EN.

Verification
REQ-033 NumCores=2: write 0x1 to 0x00, then 0x1 to 0x08 -> exit_o 0 after first, 32'h1 one cycle after second grant.
REQ-034 Write 0x7 to 0x08 -> exit_o = 32'h7 next cycle; later 0x1 to 0x00 -> exit_o stays 32'h7.
REQ-035 Write 0x1 to 0x00 twice, nothing to 0x08 -> exit_o stays 0; read 0x00 -> rdata_o = 64'h1 one cycle later.
REQ-036 TimeoutCycles=100, no writes -> exit_o = 32'hFFFF_FFFF at cycle 100; a code-0 event at cycle 100 -> no timeout.
REQ-037 TOHOST_CONSOLE_EN, char_ready_i=0, five writes of 'A'..'E' to 0x80 -> fifth sees gnt_o=0; raise ready -> 'A','B','C','D' in order, then 'E' granted.
REQ-038 Assert rst_i mid-read and in FAIL -> exit_o = 0, rvalid_o = 0, FSM back in RUN.
